// File: rtl/awb_pkg.sv
// awb_pkg: shared types and constants for the auto-white-balance statistics stage.
//   awb_state_e   - frame FSM states
//   MeanNeutral   - mean reported when no pixel contributed (all clipped)
//   MeanMin       - smallest mean ever reported; the downstream divider needs non-zero
//   awb_acc_width - accumulator/divider width for a given frame size
package awb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDivR,
    StDivG,
    StDivB,
    StDone
  } awb_state_e;

  localparam logic [7:0] MeanNeutral = 8'd128;
  localparam logic [7:0] MeanMin     = 8'd1;

  // Room for 255 * pixel_count without overflow.
  function automatic int unsigned awb_acc_width(input int unsigned img_w,
                                                input int unsigned img_h);
    return 8 + $clog2(img_w * img_h + 1);
  endfunction

endpackage

// File: rtl/awb_seq_div.sv
// awb_seq_div: W-bit restoring divider, one quotient bit per cycle.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start_i      - load dividend/divisor; W iterations follow
//   dividend_i   - numerator
//   divisor_i    - denominator (must be non-zero)
//   done_o       - one-cycle pulse, quot_o valid from this cycle on
//   quot_o       - floor(dividend/divisor), saturated to 8 bits
module awb_seq_div #(
  parameter int unsigned W = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [7:0]   quot_o
);

  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] Iters = CntW'(W);

  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            done_q, done_d;
  logic [W:0]      shifted;
  logic            ge;

  always_comb begin
    // Dividend bits shift out of quo_q into the partial remainder MSB-first.
    shifted = {rem_q, quo_q[W-1]};
    ge      = shifted >= {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = Iters;
      run_d = 1'b1;
    end else if (run_q) begin
      // When ge is false shifted < divisor, so its top bit is zero.
      rem_d = ge ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
      quo_d = {quo_q[W-2:0], ge};
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign quot_o = (|quo_q[W-1:8]) ? 8'hFF : quo_q[7:0];

endmodule

// File: rtl/awb_stats.sv
// awb_stats: per-frame gray-world R/G/B mean statistics for auto white balance.
//   clk, rst_n             - clock, asynchronous active-low reset
//   pix_valid_i, sof_i     - pixel qualifier, start of frame (qualified by pix_valid_i)
//   r_i, g_i, b_i          - pixel components
//   r/g/b_mean_o           - 8-bit channel means, held until the next frame completes
//   valid_o                - one-cycle pulse when new means are presented
//   busy_o                 - high while accumulating or dividing
// Build option: AWB_STATS_CLIP_EN excludes pixels with any component >= CLIP_TH from the
// sums and the divisor; an all-clipped frame reports neutral means.
module awb_stats
  import awb_pkg::*;
#(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter logic [7:0]  CLIP_TH = 8'd250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid_i,
  input  logic       sof_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] r_mean_o,
  output logic [7:0] g_mean_o,
  output logic [7:0] b_mean_o,
  output logic       valid_o,
  output logic       busy_o
);

  localparam int unsigned ACC_W = awb_acc_width(IMG_W, IMG_H);
  localparam int unsigned CntW  = ACC_W - 8;
  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned PhW   = $clog2(ACC_W + 1);
  localparam logic [CntW-1:0] NPixC  = CntW'(NPix);
  localparam logic [PhW-1:0]  PhLast = PhW'(ACC_W);

  awb_state_e       state_q;
  logic [ACC_W-1:0] sum_r_q, sum_g_q, sum_b_q;
  logic [CntW-1:0]  pix_cnt_q;
  logic [PhW-1:0]   phase_q;
  logic [7:0]       r_res_q, g_res_q;
  logic [7:0]       r_mean_q, g_mean_q, b_mean_q;
  logic             valid_q, busy_q;

  logic             accept, last_pix, pix_incl, div_zero, div_start, div_done;
  logic [ACC_W-1:0] sum_r_nx, sum_g_nx, sum_b_nx, dividend, divisor;
  logic [CntW-1:0]  pix_cnt_nx;
  logic [7:0]       div_quot, quot_clamped;

`ifdef AWB_STATS_CLIP_EN
  logic [CntW-1:0] incl_cnt_q;
  assign pix_incl = (r_i < CLIP_TH) && (g_i < CLIP_TH) && (b_i < CLIP_TH);
  assign divisor  = ACC_W'(incl_cnt_q);
  assign div_zero = (incl_cnt_q == '0);
`else
  assign pix_incl = 1'b1;
  assign divisor  = ACC_W'(NPix);
  assign div_zero = 1'b0;
`endif

  always_comb begin
    // sof_i with a valid pixel always opens a frame outside the divide phase.
    accept     = pix_valid_i && (((state_q == StIdle) && sof_i) || (state_q == StAccum));
    sum_r_nx   = (sof_i ? '0 : sum_r_q) + (pix_incl ? ACC_W'(r_i) : '0);
    sum_g_nx   = (sof_i ? '0 : sum_g_q) + (pix_incl ? ACC_W'(g_i) : '0);
    sum_b_nx   = (sof_i ? '0 : sum_b_q) + (pix_incl ? ACC_W'(b_i) : '0);
    pix_cnt_nx = (sof_i ? '0 : pix_cnt_q) + CntW'(1);
    last_pix   = accept && (pix_cnt_nx == NPixC);

    unique case (state_q)
      StDivR:  dividend = sum_r_q;
      StDivG:  dividend = sum_g_q;
      default: dividend = sum_b_q;
    endcase
    div_start = ((state_q == StDivR) || (state_q == StDivG) || (state_q == StDivB)) &&
                (phase_q == '0) && !div_zero;
    quot_clamped = (div_quot < MeanMin) ? MeanMin : div_quot;
  end

  awb_seq_div #(
    .W(ACC_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sum_r_q   <= '0;
      sum_g_q   <= '0;
      sum_b_q   <= '0;
      pix_cnt_q <= '0;
`ifdef AWB_STATS_CLIP_EN
      incl_cnt_q <= '0;
`endif
      phase_q   <= '0;
      r_res_q   <= '0;
      g_res_q   <= '0;
      r_mean_q  <= '0;
      g_mean_q  <= '0;
      b_mean_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            sum_r_q   <= sum_r_nx;
            sum_g_q   <= sum_g_nx;
            sum_b_q   <= sum_b_nx;
            pix_cnt_q <= pix_cnt_nx;
`ifdef AWB_STATS_CLIP_EN
            incl_cnt_q <= (sof_i ? '0 : incl_cnt_q) + CntW'(pix_incl);
`endif
            busy_q  <= 1'b1;
            phase_q <= '0;
            state_q <= last_pix ? StDivR : StAccum;
          end
        end
        StDivR, StDivG, StDivB: begin
          // The previous channel's quotient is ready in the load cycle of the next one.
          if (div_done && (state_q == StDivG)) r_res_q <= quot_clamped;
          if (div_done && (state_q == StDivB)) g_res_q <= quot_clamped;
          if (phase_q == PhLast) begin
            phase_q <= '0;
            unique case (state_q)
              StDivR:  state_q <= StDivG;
              StDivG:  state_q <= StDivB;
              default: begin
                state_q <= StDone;
                busy_q  <= 1'b0;
              end
            endcase
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StDone: begin
          if (div_zero) begin
            r_mean_q <= MeanNeutral;
            g_mean_q <= MeanNeutral;
            b_mean_q <= MeanNeutral;
          end else begin
            r_mean_q <= r_res_q;
            g_mean_q <= g_res_q;
            b_mean_q <= quot_clamped;
          end
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r_mean_o = r_mean_q;
  assign g_mean_o = g_mean_q;
  assign b_mean_o = b_mean_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;

endmodule
